// File: rtl/dircc_types_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Package  : dircc_types_pkg                                                |
// | Purpose  : Shared state encoding and send-request record for the DIRCC    |
// |            send scheduler and its users.                                  |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
package dircc_types_pkg;

  localparam int DIRCC_ADDR_W = 32;
  localparam int DIRCC_PORT_W = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_SEND  = 3'd4;
  localparam logic [2:0] ST_MARK  = 3'd5;
  localparam logic [2:0] ST_NEXT  = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    CHECK = ST_CHECK,
    SEND  = ST_SEND,
    MARK  = ST_MARK,
    NEXT  = ST_NEXT
  } sched_state_t;

  typedef struct packed {
    logic [DIRCC_ADDR_W-1:0] address;
    logic [DIRCC_PORT_W-1:0] ports;
  } send_req_t;

endpackage
`default_nettype wire

// File: rtl/dircc_send_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : dircc_send_scheduler                                           |
// | Purpose  : Round-robin scan of device RTS masks; issues one send request   |
// |            per ready slot and strobes the 'sent' writeback.               |
// |            Optional: DIRCC_SCHED_IDLE_COUNT_EN enables idle_passes count. |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module dircc_send_scheduler
  import dircc_types_pkg::*;
#(
  parameter int ADDRESS_MEM_WIDTH = 32,
  parameter int NUM_DEVICES       = 4,
  parameter int RTS_LATENCY       = 2,
  parameter int PORT_MASK_WIDTH   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  output logic [ADDRESS_MEM_WIDTH-1:0] address,
  input  logic [PORT_MASK_WIDTH-1:0]   rts_ready,
  output logic                         send_valid,
  input  logic                         send_ready,
  output logic [ADDRESS_MEM_WIDTH-1:0] send_address,
  output logic [PORT_MASK_WIDTH-1:0]   send_ports,
  output logic                         sent_we,
  output logic [ADDRESS_MEM_WIDTH-1:0] sent_address,
  output logic                         pass_done,
  output logic [15:0]                  idle_passes
);

  localparam int SLOT_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
  localparam int WAIT_W = (RTS_LATENCY > 1) ? $clog2(RTS_LATENCY) : 1;
  localparam logic [SLOT_W-1:0] C_LAST_SLOT = SLOT_W'(NUM_DEVICES - 1);

  sched_state_t                 r_state;
  logic [SLOT_W-1:0]            r_slot;
  logic [WAIT_W-1:0]            r_wait;
  logic [ADDRESS_MEM_WIDTH-1:0] r_address;
  logic                         r_send_valid;
  logic [ADDRESS_MEM_WIDTH-1:0] r_send_address;
  logic [PORT_MASK_WIDTH-1:0]   r_send_ports;
  logic                         r_sent_we;
  logic [ADDRESS_MEM_WIDTH-1:0] r_sent_address;
  logic                         r_pass_done;
  logic                         w_transfer;
  logic                         w_last_next;

  assign w_transfer  = r_send_valid && send_ready;
  assign w_last_next = (r_state == NEXT) && (r_slot == C_LAST_SLOT);

  // rts_ready is sampled on the RTS_LATENCY-th edge after address updates:
  // ISSUE's edge is the first, WAIT covers the remaining RTS_LATENCY-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_slot         <= '0;
      r_wait         <= '0;
      r_address      <= '0;
      r_send_valid   <= 1'b0;
      r_send_address <= '0;
      r_send_ports   <= '0;
      r_sent_we      <= 1'b0;
      r_sent_address <= '0;
      r_pass_done    <= 1'b0;
    end else begin
      r_sent_we   <= 1'b0;
      r_pass_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable) r_state <= ISSUE;
        end
        ISSUE: begin
          r_address <= ADDRESS_MEM_WIDTH'(r_slot);
          r_wait    <= WAIT_W'(RTS_LATENCY - 1);
          r_state   <= (RTS_LATENCY > 1) ? WAIT : CHECK;
        end
        WAIT: begin
          r_wait <= r_wait - 1'b1;
          if (r_wait == WAIT_W'(1)) r_state <= CHECK;
        end
        CHECK: begin
          if (|rts_ready) begin
            r_send_ports   <= rts_ready;
            r_send_address <= ADDRESS_MEM_WIDTH'(r_slot);
            r_send_valid   <= 1'b1;
            r_state        <= SEND;
          end else begin
            r_state <= NEXT;
          end
        end
        SEND: begin
          if (w_transfer) begin
            r_send_valid   <= 1'b0;
            r_sent_we      <= 1'b1;
            r_sent_address <= ADDRESS_MEM_WIDTH'(r_slot);
            r_state        <= MARK;
          end
        end
        MARK: begin
          r_state <= NEXT;
        end
        NEXT: begin
          if (r_slot == C_LAST_SLOT) begin
            r_slot      <= '0;
            r_pass_done <= 1'b1;
          end else begin
            r_slot <= r_slot + 1'b1;
          end
          r_state <= enable ? ISSUE : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign address      = r_address;
  assign send_valid   = r_send_valid;
  assign send_address = r_send_address;
  assign send_ports   = r_send_ports;
  assign sent_we      = r_sent_we;
  assign sent_address = r_sent_address;
  assign pass_done    = r_pass_done;

`ifdef DIRCC_SCHED_IDLE_COUNT_EN
  logic        r_pass_sent;
  logic [15:0] r_idle_passes;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pass_sent   <= 1'b0;
      r_idle_passes <= '0;
    end else if (w_transfer) begin
      r_pass_sent   <= 1'b1;
      r_idle_passes <= '0;
    end else if (w_last_next) begin
      r_pass_sent <= 1'b0;
      if (!r_pass_sent && (r_idle_passes != 16'hFFFF))
        r_idle_passes <= r_idle_passes + 16'd1;
    end
  end

  assign idle_passes = r_idle_passes;
`else
  assign idle_passes = 16'd0;
`endif

endmodule
`default_nettype wire
